// File: rtl/seizure_classifier.sv
// Seizure detection back end: per-channel feature/baseline capture, weighted vote score,
// and a consecutive-detection / stimulation / refractory controller.

module seizure_classifier_lane #(
    parameter int FEAT_WIDTH = 40,
    parameter int BASE_WIDTH = 49,
    parameter int BASE_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic                         valid,
    input  logic                         clear,
    input  logic [FEAT_WIDTH-1:0]        feat_in,
    input  logic [BASE_WIDTH-1:0]        base_in,
    output logic                         pending,
    output logic                         hit
);
    localparam int CMP_W = (FEAT_WIDTH + BASE_SHIFT > BASE_WIDTH) ? FEAT_WIDTH + BASE_SHIFT : BASE_WIDTH;

    logic [FEAT_WIDTH-1:0] feat_q, feat_cur;
    logic [BASE_WIDTH-1:0] base_q, base_cur;
    logic                  flag;
    logic [CMP_W-1:0]      feat_scaled, base_ext;

    // A strobe in the completing cycle takes part in that round, so look through the holding regs.
    assign feat_cur    = valid ? feat_in : feat_q;
    assign base_cur    = valid ? base_in : base_q;
    assign pending     = flag | valid;
    assign feat_scaled = CMP_W'(feat_cur) << BASE_SHIFT;
    assign base_ext    = CMP_W'(base_cur);
    assign hit         = !feat_cur[FEAT_WIDTH-1] && (feat_cur != '0) && (feat_scaled > base_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q <= '0;
            base_q <= '0;
            flag   <= 1'b0;
        end else if (!hold) begin
            if (valid) begin
                feat_q <= feat_in;
                base_q <= base_in;
            end
            flag <= clear ? 1'b0 : pending;
        end
    end
endmodule

module seizure_classifier #(
    parameter int NUM_FEAT     = 6,
    parameter int FEAT_WIDTH   = 40,
    parameter int BASE_WIDTH   = 49,
    parameter int BASE_SHIFT   = 3,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CONSEC       = 3,
    parameter int STIM_LEN     = 1000,
    parameter int REFRACT      = 4000,
    parameter int CNT_WIDTH    = 16,
    localparam int SCORE_WIDTH = WEIGHT_WIDTH + $clog2(NUM_FEAT) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_FEAT*FEAT_WIDTH-1:0]   feat_in,
    input  logic [NUM_FEAT-1:0]              feat_valid,
    input  logic [NUM_FEAT*BASE_WIDTH-1:0]   base_in,
    input  logic [NUM_FEAT*WEIGHT_WIDTH-1:0] weights,
    input  logic [SCORE_WIDTH-1:0]           sum_thresh,
    output logic [SCORE_WIDTH-1:0]           score,
    output logic                             decision,
    output logic                             decision_valid,
    output logic                             stimulation,
    output logic [1:0]                       fsm_state
);
    localparam int CONS_W = $clog2(CONSEC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        STIM    = 2'd2,
        REFR    = 2'd3
    } state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    timer;
    logic [CONS_W-1:0]       consec_cnt;
    logic [NUM_FEAT-1:0]     pending, hit;
    logic                    round_done;
    logic [SCORE_WIDTH-1:0]  score_next;

    genvar g;
    generate
        for (g = 0; g < NUM_FEAT; g++) begin : g_lane
            seizure_classifier_lane #(
                .FEAT_WIDTH (FEAT_WIDTH),
                .BASE_WIDTH (BASE_WIDTH),
                .BASE_SHIFT (BASE_SHIFT)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .hold    (en),
                .valid   (feat_valid[g]),
                .clear   (round_done),
                .feat_in (feat_in[g*FEAT_WIDTH +: FEAT_WIDTH]),
                .base_in (base_in[g*BASE_WIDTH +: BASE_WIDTH]),
                .pending (pending[g]),
                .hit     (hit[g])
            );
        end
    endgenerate

    assign round_done = &pending;

    // Width leaves room for NUM_FEAT maximal weights, so the sum cannot wrap.
    always_comb begin
        score_next = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            if (hit[i])
                score_next = score_next + SCORE_WIDTH'(weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        end
    end

    assign stimulation = (state == STIM) && !en;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            consec_cnt     <= '0;
            score          <= '0;
            decision       <= 1'b0;
            decision_valid <= 1'b0;
        end else if (!en) begin
            if (round_done) begin
                score    <= score_next;
                decision <= (score_next >= sum_thresh);
            end
            decision_valid <= round_done;

            case (state)
                IDLE: begin
                    if (decision_valid && decision) begin
                        if (CONSEC == 1) begin
                            state <= STIM;
                            timer <= '0;
                        end else begin
                            state      <= ARMING;
                            consec_cnt <= CONS_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (decision_valid) begin
                        if (!decision) begin
                            state      <= IDLE;
                            consec_cnt <= '0;
                        end else if (consec_cnt == CONS_W'(CONSEC - 1)) begin
                            state      <= STIM;
                            timer      <= '0;
                            consec_cnt <= '0;
                        end else begin
                            consec_cnt <= consec_cnt + CONS_W'(1);
                        end
                    end
                end
                STIM: begin
                    if (timer == CNT_WIDTH'(STIM_LEN - 1)) begin
                        state <= REFR;
                        timer <= '0;
                    end else begin
                        timer <= timer + CNT_WIDTH'(1);
                    end
                end
                REFR: begin
                    if (timer == CNT_WIDTH'(REFRACT - 1)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seizure_classifier.sv
// Randomised and directed bench for seizure_classifier against a round/timestamp reference model.

module tb_seizure_classifier;
    localparam int NF = 3, FW = 8, BW = 11, BS = 3, WW = 4;
    localparam int CONSEC = 2, SL = 4, RF = 6, CW = 16;
    localparam int SW = WW + $clog2(NF) + 1;
    localparam int THR = 3;

    logic              clk = 1'b0;
    logic              rst, en;
    logic [NF*FW-1:0]  feat_in;
    logic [NF-1:0]     feat_valid;
    logic [NF*BW-1:0]  base_in;
    logic [NF*WW-1:0]  weights;
    logic [SW-1:0]     sum_thresh, score;
    logic              decision, decision_valid, stimulation;
    logic [1:0]        fsm_state;

    seizure_classifier #(
        .NUM_FEAT(NF), .FEAT_WIDTH(FW), .BASE_WIDTH(BW), .BASE_SHIFT(BS), .WEIGHT_WIDTH(WW),
        .CONSEC(CONSEC), .STIM_LEN(SL), .REFRACT(RF), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .feat_in(feat_in), .feat_valid(feat_valid),
        .base_in(base_in), .weights(weights), .sum_thresh(sum_thresh), .score(score),
        .decision(decision), .decision_valid(decision_valid), .stimulation(stimulation),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int wt[NF] = '{1, 2, 3};

    // Reference: held values per channel, last round outcome, and the stimulation episode as a
    // window of enabled-edge timestamps.
    int  m_feat[NF], m_base[NF];
    bit  m_flag[NF];
    int  m_score;
    bit  m_dec, m_dv;
    int  etime, streak, stim_start;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int phase_at(input int t);
        if (stim_start >= 0 && t >= stim_start && t < stim_start + SL) return 2;
        if (stim_start >= 0 && t >= stim_start + SL && t < stim_start + SL + RF) return 3;
        return (streak > 0) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int sc;
        bit all;
        if (rst) begin
            for (int i = 0; i < NF; i++) begin m_feat[i] = 0; m_base[i] = 0; m_flag[i] = 0; end
            m_score = 0; m_dec = 0; m_dv = 0;
            etime = 0; streak = 0; stim_start = -1;
            return;
        end
        if (en) return;
        if (m_dv && phase_at(etime) < 2) begin
            if (m_dec) begin
                streak++;
                if (streak >= CONSEC) begin
                    stim_start = etime + 1;
                    streak = 0;
                end
            end else begin
                streak = 0;
            end
        end
        all = 1;
        for (int i = 0; i < NF; i++) begin
            if (feat_valid[i]) begin
                m_feat[i] = int'($signed(feat_in[i*FW +: FW]));
                m_base[i] = int'(base_in[i*BW +: BW]);
                m_flag[i] = 1;
            end
            all &= m_flag[i];
        end
        if (all) begin
            sc = 0;
            for (int i = 0; i < NF; i++)
                if (m_feat[i] > 0 && m_feat[i] * (1 << BS) > m_base[i]) sc += wt[i];
            m_score = sc;
            m_dec = (sc >= THR);
            m_dv = 1;
            for (int i = 0; i < NF; i++) m_flag[i] = 0;
        end else begin
            m_dv = 0;
        end
        etime++;
    endtask

    task automatic check_outputs();
        int ph;
        ph = phase_at(etime);
        chk("score", score, m_score);
        chk("decision", decision, m_dec);
        chk("decision_valid", decision_valid, m_dv);
        chk("stimulation", stimulation, (ph == 2 && !en) ? 1 : 0);
        chk("fsm_state", fsm_state, ph);
    endtask

    task automatic cycle(input logic [NF-1:0] v, input int f0, input int f1, input int f2,
                         input int b0, input int b1, input int b2, input logic e, input logic r);
        feat_valid = v;
        feat_in    = {FW'(f2), FW'(f1), FW'(f0)};
        base_in    = {BW'(b2), BW'(b1), BW'(b0)};
        en         = e;
        rst        = r;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic pos_round();
        cycle(3'b111, 20, 20, 20, 0, 0, 0, 1'b0, 1'b0);
    endtask

    int stim_cnt;

    initial begin
        weights    = {WW'(wt[2]), WW'(wt[1]), WW'(wt[0])};
        sum_thresh = SW'(THR);
        feat_valid = '0; feat_in = '0; base_in = '0; en = 1'b0; rst = 1'b1;
        etime = 0; streak = 0; stim_start = -1;

        // Reset state
        cycle(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        cycle(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        chk("reset_state", {score, decision, decision_valid, stimulation, fsm_state}, 0);

        // Staggered valids, equality boundary on ch1 (80 > 80 fails)
        cycle(3'b001, 10, 0, 0, 79, 0, 0, 1'b0, 1'b0);
        chk("stagger_no_dv0", decision_valid, 0);
        cycle(3'b010, 0, 10, 0, 0, 80, 0, 1'b0, 1'b0);
        chk("stagger_no_dv1", decision_valid, 0);
        cycle(3'b100, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("stagger_dv", decision_valid, 1);
        chk("stagger_score", score, 1);
        chk("stagger_dec", decision, 0);
        idle(1);
        chk("dv_one_cycle", decision_valid, 0);

        // Negative feature on ch2 must never hit even with zero baseline
        cycle(3'b001, 10, 0, 0, 79, 0, 0, 1'b0, 1'b0);
        cycle(3'b010, 0, 10, 0, 0, 80, 0, 1'b0, 1'b0);
        cycle(3'b100, 0, 0, -5, 0, 0, 0, 1'b0, 1'b0);
        chk("neg_feat_score", score, 1);
        idle(2);

        // Two positive rounds trigger stimulation
        pos_round();
        chk("round1_score", score, 6);
        pos_round();
        chk("round2_arming", fsm_state, 1);
        stim_cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            idle(1);
            if (stimulation) stim_cnt++;
            if (i == 5) chk("refract_entry", fsm_state, 3);
        end
        chk("stim_len", stim_cnt, SL);
        chk("idle_after_refract", fsm_state, 0);

        // Positive then negative: arm and fall back
        pos_round();
        cycle(3'b111, 1, 1, 1, 2047, 2047, 2047, 1'b0, 1'b0);
        chk("arming_seen", fsm_state, 1);
        idle(1);
        chk("back_to_idle", fsm_state, 0);
        chk("no_stim", stimulation, 0);
        idle(2);

        // Rounds finishing inside the refractory window are ignored
        pos_round();
        pos_round();
        idle(5);
        for (int i = 0; i < 3; i++) begin
            pos_round();
            chk("refract_dv", decision_valid, 1);
            chk("refract_no_stim", stimulation, 0);
        end
        idle(12);

        // Disable during stimulation, then reset mid-STIM
        pos_round();
        pos_round();
        idle(2);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
            chk("disabled_stim", stimulation, 0);
        end
        stim_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (stimulation) stim_cnt++;
        end
        chk("stim_resume", stim_cnt, 2);
        idle(8);
        pos_round();
        pos_round();
        idle(2);
        cycle(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        chk("rst_mid_stim", {stimulation, fsm_state}, 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int f[NF], b[NF];
            for (int i = 0; i < NF; i++) begin
                f[i] = ($urandom_range(0, 4) == 0) ? -int'($urandom_range(0, 128)) : int'($urandom_range(1, 127));
                b[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 2047));
            end
            cycle(3'($urandom_range(0, 7)), f[0], f[1], f[2], b[0], b[1], b[2],
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
